// File: rtl/edge_detect_pkg.sv
// Shared constants and helpers for the multi-channel edge detector.
package edge_detect_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Bits needed to hold 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/edge_detect_ch.sv
// One channel: synchroniser, debounce filter, edge pulses, sticky pending
// flag and saturating event counter.
module edge_detect_ch
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_i,
  input  logic [1:0]       mode_i,
  input  logic             clr_i,
  input  logic             cnt_clr_i,
  output logic             level_o,
  output logic             rise_o,
  output logic             down_o,
  output logic             pending_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int                DCNT_W    = clog2_min1(DEB_CYCLES);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DCNT_W-1:0]      dcnt_q, dcnt_d;
  logic                   filt_q, filt_d;
  logic                   filt_dly_q;
  logic                   pending_q, pending_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   s;
  logic                   ev;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = a_i;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  assign s = sync_q[SYNC_STAGES-1];

  // The filtered level only moves after DEB_CYCLES consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    dcnt_d = dcnt_q;
    if (s == filt_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DCNT_LAST) begin
      filt_d = s;
      dcnt_d = '0;
    end else begin
      dcnt_d = dcnt_q + DCNT_W'(1);
    end
  end

  assign rise_o  = filt_q & ~filt_dly_q;
  assign down_o  = ~filt_q & filt_dly_q;
  assign level_o = filt_q;

  assign ev = (rise_o & ((mode_i == MODE_RISE) || (mode_i == MODE_BOTH))) |
              (down_o & ((mode_i == MODE_FALL) || (mode_i == MODE_BOTH)));

  // A set in the same cycle as a clear wins.
  assign pending_d = ev | (pending_q & ~clr_i);

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = ev ? CNT_W'(1) : '0;
    end else if (ev && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      dcnt_q     <= '0;
      filt_q     <= 1'b0;
      filt_dly_q <= 1'b0;
      pending_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync_q     <= sync_d;
      dcnt_q     <= dcnt_d;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pending_o = pending_q;
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/edge_detect_multi.sv
// N_CH independent edge-detect channels sharing one interrupt line.
module edge_detect_multi
  import edge_detect_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       a,
  input  logic [2*N_CH-1:0]     mode,
  input  logic [N_CH-1:0]       clr,
  input  logic [N_CH-1:0]       cnt_clr,
  output logic [N_CH-1:0]       level,
  output logic [N_CH-1:0]       rise,
  output logic [N_CH-1:0]       down,
  output logic [N_CH-1:0]       pending,
  output logic                  irq,
  output logic [N_CH*CNT_W-1:0] cnt
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_detect_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_i       (a[i]),
      .mode_i    (mode[2*i +: 2]),
      .clr_i     (clr[i]),
      .cnt_clr_i (cnt_clr[i]),
      .level_o   (level[i]),
      .rise_o    (rise[i]),
      .down_o    (down[i]),
      .pending_o (pending[i]),
      .cnt_o     (cnt[CNT_W*i +: CNT_W])
    );
  end

  assign irq = |pending;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench for edge_detect_multi: default 4-channel instance plus a
// 1-channel CNT_W=2 instance for counter saturation.
module tb_edge_detect_multi;

  logic        clk;
  logic        rst_n;
  logic [3:0]  a, clr, cnt_clr;
  logic [7:0]  mode;
  logic [3:0]  level, rise, down, pending;
  logic        irq;
  logic [31:0] cnt;

  logic [0:0]  sat_a, sat_clr, sat_cnt_clr;
  logic [1:0]  sat_mode;
  logic [0:0]  sat_level, sat_rise, sat_down, sat_pending;
  logic        sat_irq;
  logic [1:0]  sat_cnt;

  int n_cmp;
  int n_err;

  edge_detect_multi dut (
    .clk (clk), .rst_n (rst_n), .a (a), .mode (mode), .clr (clr),
    .cnt_clr (cnt_clr), .level (level), .rise (rise), .down (down),
    .pending (pending), .irq (irq), .cnt (cnt)
  );

  edge_detect_multi #(.N_CH(1), .CNT_W(2)) dut_sat (
    .clk (clk), .rst_n (rst_n), .a (sat_a), .mode (sat_mode), .clr (sat_clr),
    .cnt_clr (sat_cnt_clr), .level (sat_level), .rise (sat_rise),
    .down (sat_down), .pending (sat_pending), .irq (sat_irq), .cnt (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] cnt_of(input int ch);
    return cnt[8*ch +: 8];
  endfunction

  // Count pulses on one channel over n cycles.
  task automatic watch(input int ch, input int n, output int rises, output int downs, output int both);
    rises = 0; downs = 0; both = 0;
    for (int k = 0; k < n; k++) begin
      tick(1);
      if (rise[ch]) rises++;
      if (down[ch]) downs++;
      if (rise[ch] && down[ch]) both++;
    end
  endtask

  initial begin
    int r, d, b;
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; a = '0; mode = '0; clr = '0; cnt_clr = '0;
    sat_a = '0; sat_mode = 2'b11; sat_clr = '0; sat_cnt_clr = '0;

    #3;
    check("rst_level", 32'(level), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_cnt", cnt, 32'h0);
    check("rst_sat_cnt", 32'(sat_cnt), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2);

    // ch0 rise, ch1 rise, ch2 off, ch3 rise
    mode = 8'b01_00_01_01;

    // Clean rise on ch0: filt updates at edge 5.
    a[0] = 1'b1;
    tick(5);
    check("t1_level_e4", 32'(level), 32'h0);
    check("t1_rise_e4", 32'(rise), 32'h0);
    tick(1);
    check("t1_level_e5", 32'(level), 32'h1);
    check("t1_rise_e5", 32'(rise), 32'h1);
    check("t1_pending_e5", 32'(pending), 32'h0);
    tick(1);
    check("t1_rise_e6", 32'(rise), 32'h0);
    check("t1_pending_e6", 32'(pending), 32'h1);
    check("t1_irq", 32'(irq), 32'h1);
    check("t1_cnt0", 32'(cnt_of(0)), 32'h1);
    clr = 4'b0001;
    tick(1);
    clr = '0;
    check("t1_clr", 32'(pending), 32'h0);
    check("t1_irq_clr", 32'(irq), 32'h0);

    // Glitch rejection on ch1: 3 cycles high is too short.
    a[1] = 1'b1;
    tick(3);
    a[1] = 1'b0;
    watch(1, 12, r, d, b);
    check("t2_glitch_rises", 32'(r), 32'h0);
    check("t2_glitch_level", 32'(level[1]), 32'h0);
    check("t2_glitch_pending", 32'(pending[1]), 32'h0);
    check("t2_glitch_cnt1", 32'(cnt_of(1)), 32'h0);
    a[1] = 1'b1;
    tick(4);
    a[1] = 1'b0;
    tick(2);
    check("t2_rise_4cyc", 32'(rise), 32'h2);
    tick(1);
    check("t2_pending", 32'(pending), 32'h2);
    check("t2_cnt1", 32'(cnt_of(1)), 32'h1);
    tick(10);
    check("t2_level_back", 32'(level[1]), 32'h0);
    check("t2_cnt1_fall_ignored", 32'(cnt_of(1)), 32'h1);
    clr = 4'b0010;
    tick(1);
    clr = '0;

    // ch2 mode off: pulses still present, no event.
    a[2] = 1'b1;
    watch(2, 10, r, d, b);
    check("t3_off_rises", 32'(r), 32'h1);
    a[2] = 1'b0;
    watch(2, 12, r, d, b);
    check("t3_off_downs", 32'(d), 32'h1);
    check("t3_off_both", 32'(b), 32'h0);
    check("t3_off_pending", 32'(pending), 32'h0);
    check("t3_off_cnt2", 32'(cnt_of(2)), 32'h0);
    // ch2 mode both: two events.
    mode = 8'b01_11_01_01;
    a[2] = 1'b1;
    watch(2, 10, r, d, b);
    a[2] = 1'b0;
    watch(2, 12, r, d, b);
    check("t3_both_cnt2", 32'(cnt_of(2)), 32'h2);
    check("t3_both_pending", 32'(pending), 32'h4);
    clr = 4'b0100;
    tick(1);
    clr = '0;
    check("t3_clr_irq", 32'(irq), 32'h0);

    // Set/clear collision on ch3.
    a[3] = 1'b1;
    tick(6);
    check("t4_rise3", 32'(rise), 32'h8);
    clr = 4'b1000;
    tick(1);
    check("t4_set_wins", 32'(pending), 32'h8);
    check("t4_cnt3", 32'(cnt_of(3)), 32'h1);
    tick(1);
    clr = '0;
    check("t4_cleared", 32'(pending), 32'h0);
    check("t4_irq", 32'(irq), 32'h0);

    // Saturation with CNT_W=2, both edges counted.
    for (int k = 0; k < 5; k++) begin
      sat_a = ~sat_a;
      tick(10);
      if (k == 1) check("t5_cnt_after2", 32'(sat_cnt), 32'h2);
    end
    check("t5_cnt_sat", 32'(sat_cnt), 32'h3);
    sat_a = 1'b0;
    tick(6);
    check("t5_down", 32'(sat_down), 32'h1);
    sat_cnt_clr = 1'b1;
    tick(1);
    check("t5_clr_with_ev", 32'(sat_cnt), 32'h1);
    tick(1);
    sat_cnt_clr = 1'b0;
    check("t5_clr_plain", 32'(sat_cnt), 32'h0);

    // Reset mid-debounce on ch1; ch0/ch3 are high, ch2 low.
    a[1] = 1'b1;
    tick(2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_level", 32'(level), 32'h0);
    check("t6_rst_pending", 32'(pending), 32'h0);
    check("t6_rst_irq", 32'(irq), 32'h0);
    check("t6_rst_cnt", cnt, 32'h0);
    r = 0;
    for (int k = 0; k < 2; k++) begin
      tick(1);
      if (rise != 4'b0 || down != 4'b0) r++;
    end
    check("t6_no_pulse_in_rst", 32'(r), 32'h0);
    rst_n = 1'b1;
    r = 0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      if (rise != 4'b0 || down != 4'b0) r++;
    end
    check("t6_quiet_e0_e4", 32'(r), 32'h0);
    check("t6_level_e4", 32'(level), 32'h0);
    tick(1);
    check("t6_rise_e5", 32'(rise), 32'hb);
    check("t6_level_e5", 32'(level), 32'hb);
    tick(1);
    check("t6_rise_e6", 32'(rise), 32'h0);
    check("t6_pending_e6", 32'(pending), 32'hb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
Parametrised multi-channel edge detector for asynchronous or noisy level inputs. Each channel has a synchroniser, a debounce filter, rise/fall pulse generation, a per-channel event-mode select, a sticky pending flag with clear, and a saturating event counter. All channels feed a single interrupt output for the control/status block.

Parameters:
N_CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=1)
DEB_CYCLES, 4, consecutive differing samples required before the filtered level changes (>=1)
CNT_W, 8, width of each per-channel event counter

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
a  input  N_CH  raw level inputs; may be asynchronous to clk
mode  input  2*N_CH  per-channel event select; bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
clr  input  N_CH  per-channel pending clear, 1-cycle strobe
cnt_clr  input  N_CH  per-channel counter clear, 1-cycle strobe
level  output  N_CH  debounced level
rise  output  N_CH  1-cycle pulse on each debounced 0->1
down  output  N_CH  1-cycle pulse on each debounced 1->0
pending  output  N_CH  sticky event flags
irq  output  1  OR of all pending bits
cnt  output  N_CH*CNT_W  per-channel event counts; channel i at [CNT_W*i +: CNT_W]

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk release): synchroniser flops, filtered level, delayed level, debounce counters, pending and counters all go to 0. Outputs level/rise/down/pending/irq/cnt are 0 while rst_n is low.
- Synchroniser: SYNC_STAGES-deep flop chain per channel. s = last stage.
- Debounce, per channel:
  - if s == filt, dcnt <= 0.
  - else if dcnt == DEB_CYCLES-1, filt <= s and dcnt <= 0.
  - else dcnt <= dcnt+1.
  - A glitch shorter than DEB_CYCLES synchronised samples never changes filt.
  - dcnt width is clog2(DEB_CYCLES), minimum 1.
- level = filt. filt_d <= filt every cycle.
- rise = filt & ~filt_d; down = ~filt & filt_d. Both are flop-to-output with gates only, each exactly 1 cycle wide, and never high together. They are independent of mode.
- Latency: a set up before edge 0 and held stable -> filt updates at edge SYNC_STAGES+DEB_CYCLES-1 -> rise/down high for the following cycle only.
- Event: ev[i] = (rise[i] & mode[2i]) | (down[i] & mode[2i+1]). A mode change applies from the next cycle; there is no retroactive event.
- Pending: set on ev; cleared by clr. ev and clr in the same cycle -> pending stays 1 (set wins). clr with pending=0 has no effect.
- irq = |pending (combinational OR of flops).
- Counter: +1 on ev and saturates at 2^CNT_W-1 (no wrap). cnt_clr -> 0. cnt_clr and ev in the same cycle -> counter = 1.
- Channels are fully independent. Simultaneous events on all channels are all captured.
- Reset mid-debounce or mid-pulse: everything returns to 0 and no pulse is emitted after release. If a is held at 1 across release, a rise is reported SYNC_STAGES+DEB_CYCLES-1 edges after the first post-release edge.

Decomposition:
- Package edge_detect_pkg: mode encoding constants MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11; clog2 helper for the dcnt width.
- Sub-module edge_detect_ch: one channel (synchroniser, debounce, pulses, pending, counter) with the same parameters and scalar ports. The top generates N_CH instances and ORs the irq.

Test Plan:
- Clean rise, defaults, mode=01 on ch0: a[0] 0->1 before edge 0 -> level[0]=1 after edge 5; rise[0] high exactly between edges 5 and 6; pending[0]=1, irq=1, cnt ch0=1.
- Glitch rejection: a[1] high for 3 cycles, then low -> level/rise/pending/cnt for ch1 stay 0. Then held high 4 cycles -> rise[1] fires.
- Mode off/both on ch2: mode=00 with a toggle -> rise and down pulse, pending=0, cnt=0. mode=11 with 0->1->0 (each held 10 cycles) -> cnt=2, pending=1.
- Set/clear collision: align clr[3] with an event cycle -> pending[3] stays 1. clr[3] on the next cycle -> pending[3]=0, irq=0.
- Saturation, CNT_W=2: 5 qualified edges -> cnt=3. cnt_clr coincident with an event -> cnt=1.
- Reset mid-operation: assert rst_n low 2 cycles after a 0->1 -> all outputs 0, no rise pulse. With a held high through release -> rise fires 5 edges after the first post-release edge.
